// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Register map, STATUS bit positions and FSM state types for the
//           UART bus slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic [7:0] REG_DATA    = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h02;
  localparam logic [7:0] REG_DIVISOR = 8'h04;
  localparam logic [7:0] REG_CTRL    = 8'h06;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_BUSY  = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RXOVR    = 3;
  localparam int ST_TXOVR    = 4;
  localparam int ST_FERR     = 5;

  typedef enum logic [0:0] {B_IDLE, B_ACK} bus_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module  : uart_rx_core
// Brief   : 8N1 receiver: rxd synchronizer, start-bit validation, mid-bit
//           sampling; pulses o_done or o_frame_err once per frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rxd,
  input  logic [15:0] i_divisor,
  output logic        o_done,
  output logic [7:0]  o_data,
  output logic        o_frame_err
);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        prev_q, prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;

  logic        w_rx;
  logic [15:0] w_half_m1;

  assign w_rx      = sync_q[1];
  // (DIVISOR+1)/2 - 1, valid because the divisor is never zero
  assign w_half_m1 = (div_q - 16'd1) >> 1;

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], i_rxd};
    prev_d  = w_rx;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (prev_q && !w_rx) begin
          state_d = R_START;
          cnt_d   = 16'd0;
          div_d   = i_divisor;
        end
      end
      R_START: begin
        if (cnt_q == w_half_m1) begin
          cnt_d   = 16'd0;
          div_d   = i_divisor;
          bit_d   = 3'd0;
          state_d = w_rx ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_DATA: begin
        if (cnt_q == div_q) begin
          cnt_d   = 16'd0;
          div_d   = i_divisor;
          shift_d = {w_rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_STOP: begin
        if (cnt_q == div_q) begin
          state_d = R_IDLE;
          done_d  = w_rx;
          ferr_d  = !w_rx;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= R_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= 16'd0;
      div_q   <= 16'd1;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_done      = done_q;
  assign o_data      = shift_q;
  assign o_frame_err = ferr_q;

endmodule

`default_nettype wire

// File: rtl/uart_bus_slave.sv
// ============================================================================
// Module  : uart_bus_slave
// Brief   : UART peripheral on the 16-bit ds/ack bus: register file, bus
//           handshake FSM and 8N1 transmitter; receiver in uart_rx_core.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_bus_slave
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  bus_state_e  bus_q, bus_d;
  logic [15:0] rdata_q, rdata_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        tx_empty_q, tx_empty_d;
  logic [15:0] div_q, div_d;
  logic        txie_q, txie_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rxovr_q, rxovr_d;
  logic        txovr_q, txovr_d;
  logic        ferr_q, ferr_d;

  logic        w_rx_done;
  logic [7:0]  w_rx_data;
  logic        w_rx_ferr;
  logic        w_access, w_wr, w_rd_data, w_tx_busy, w_tx_tick;
  logic [7:0]  w_off;
  logic [15:0] w_rdval;
  logic        w_unused;

  assign w_unused  = addr[0];
  assign w_off     = {addr[7:1], 1'b0};
  assign w_access  = (bus_q == B_IDLE) && ds;
  assign w_wr      = w_access && we;
  assign w_rd_data = w_access && !we && (w_off == REG_DATA);
  assign w_tx_busy = (tx_state_q != T_IDLE);
  assign w_tx_tick = (tx_cnt_q == tx_div_q);

  uart_rx_core u_rx (
    .clk         (clk),
    .rst         (reset),
    .i_rxd       (rxd),
    .i_divisor   (div_q),
    .o_done      (w_rx_done),
    .o_data      (w_rx_data),
    .o_frame_err (w_rx_ferr)
  );

  always_comb begin
    w_rdval = 16'h0000;
    case (w_off)
      REG_DATA:    w_rdval = {8'h00, rx_byte_q};
      REG_STATUS:  w_rdval = {10'd0, ferr_q, txovr_q, rxovr_q, rx_valid_q, w_tx_busy, tx_empty_q};
      REG_DIVISOR: w_rdval = div_q;
      REG_CTRL:    w_rdval = {15'd0, txie_q};
      default:     w_rdval = 16'h0000;
    endcase
  end

  always_comb begin
    bus_d      = bus_q;
    rdata_d    = rdata_q;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    div_d      = div_q;
    txie_d     = txie_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rxovr_d    = rxovr_q;
    txovr_d    = txovr_q;
    ferr_d     = ferr_q;

    case (bus_q)
      B_IDLE: if (ds) begin
        bus_d   = B_ACK;
        rdata_d = we ? 16'h0000 : w_rdval;
      end
      B_ACK: if (!ds) begin
        bus_d   = B_IDLE;
        rdata_d = 16'h0000;
      end
      default: bus_d = B_IDLE;
    endcase

    // Clears are applied first so a same-edge hardware set overrides them
    if (w_wr) begin
      case (w_off)
        REG_DATA: begin
          if (tx_empty_q) begin
            tx_hold_d  = wdata[7:0];
            tx_empty_d = 1'b0;
          end else begin
            txovr_d = 1'b1;
          end
        end
        REG_STATUS: begin
          if (wdata[ST_RXOVR]) rxovr_d = 1'b0;
          if (wdata[ST_TXOVR]) txovr_d = 1'b0;
          if (wdata[ST_FERR])  ferr_d  = 1'b0;
        end
        REG_DIVISOR: div_d  = (wdata == 16'd0) ? 16'd1 : wdata;
        REG_CTRL:    txie_d = wdata[0];
        default: ;
      endcase
    end

    if (w_rd_data) rx_valid_d = 1'b0;
    if (w_rx_done) begin
      if (rx_valid_q && !w_rd_data) begin
        rxovr_d = 1'b1;
      end else begin
        rx_byte_d  = w_rx_data;
        rx_valid_d = 1'b1;
      end
    end
    if (w_rx_ferr) ferr_d = 1'b1;

    case (tx_state_q)
      T_IDLE: if (!tx_empty_q) begin
        tx_state_d = T_START;
        tx_shift_d = tx_hold_q;
        tx_empty_d = 1'b1;
        tx_cnt_d   = 16'd0;
        tx_div_d   = div_q;
      end
      T_START: begin
        if (w_tx_tick) begin
          tx_state_d = T_DATA;
          tx_bit_d   = 3'd0;
          tx_cnt_d   = 16'd0;
          tx_div_d   = div_q;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      T_DATA: begin
        if (w_tx_tick) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_cnt_d   = 16'd0;
          tx_div_d   = div_q;
          if (tx_bit_q == 3'd7) tx_state_d = T_STOP;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      T_STOP: begin
        if (w_tx_tick) begin
          tx_cnt_d = 16'd0;
          tx_div_d = div_q;
          if (!tx_empty_q) begin
            tx_state_d = T_START;
            tx_shift_d = tx_hold_q;
            tx_empty_d = 1'b1;
          end else begin
            tx_state_d = T_IDLE;
          end
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q      <= B_IDLE;
      rdata_q    <= 16'h0000;
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_hold_q  <= 8'h00;
      tx_empty_q <= 1'b1;
      div_q      <= DEFAULT_DIV;
      txie_q     <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rxovr_q    <= 1'b0;
      txovr_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      bus_q      <= bus_d;
      rdata_q    <= rdata_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      div_q      <= div_d;
      txie_q     <= txie_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rxovr_q    <= rxovr_d;
      txovr_q    <= txovr_d;
      ferr_q     <= ferr_d;
    end
  end

  // txd decodes straight from flops so reset forces the line idle at once
  always_comb begin
    txd = 1'b1;
    case (tx_state_q)
      T_START: txd = 1'b0;
      T_DATA:  txd = tx_shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign ack   = (bus_q == B_ACK);
  assign rdata = rdata_q;
  assign irq   = rx_valid_q | (tx_empty_q & txie_q);

endmodule

`default_nettype wire
